cmp_search: RTL and testbench
=============================

# cmp_search

Sequential binary-search engine that drives the `b` operand of an external magnitude comparator and consumes its `a_eq_b`/`a_gt_b`/`a_lt_b` flags to recover the unknown value on the comparator's `a` operand. It sits on the opposite side of the comparator interface from the comparators in this codebase. It issues guesses, reads the verdicts and converges in at most W+1 probes. The comparator is combinational: flags depend only on the current `guess` and the target.

## Interface
- `W`, default 4: operand width; search range is 0 .. 2^W-1.
- `CW` (localparam) = $clog2(W+2): probe-counter width.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: synchronous reset, active-low; one clock, synchronous active-low reset.
- `start` input 1: begin a search; sampled only in IDLE.
- `guess` output W: registered value driven to the comparator `b` input.
- `a_eq_b` input 1: comparator flag, target == guess.
- `a_gt_b` input 1: comparator flag, target > guess.
- `a_lt_b` input 1: comparator flag, target < guess.
- `busy` output 1: high in PROBE.
- `done` output 1: one-cycle pulse when a search ends.
- `err` output 1: last search ended abnormally; held until the next start.
- `result` output W: found value, or last guess on error; held until the next start.
- `probes` output CW: number of flag samples taken in the last or current search.

## Operation
- Internal bounds `lo` and `hi` are W+1 bits wide; all midpoint arithmetic is W+1 bits, so there is no overflow.
- States:
  - IDLE → PROBE on `start`.
  - PROBE → PROBE while searching.
  - PROBE → DONE on a match or on an error.
  - DONE → IDLE unconditionally.
- On `start` in IDLE:
  - set `lo`=0, `hi`=2^W-1, `guess`=(2^W-1)>>1.
  - clear `err` and set `probes`=0.
  - `result` is unchanged until the search ends.
- Each PROBE edge samples the flags and increments `probes`, then acts on the flags:
  - Flags not exactly one-hot (none set, or more than one set): `err`=1, `result`=`guess`, go to DONE.
  - `a_eq_b`: `result`=`guess`, go to DONE.
  - `a_gt_b`: `lo`=`guess`+1.
  - `a_lt_b`: `hi`=`guess`-1. When `guess`=0, `hi` becomes all ones in W+1 bits; treat this as below `lo` (signed compare, or test for the borrow).
- After a `gt` or `lt` update, if the new `lo` > new `hi`, the range is empty: `err`=1, `result`=`guess`, go to DONE.
- Otherwise, `guess`=(new `lo` + new `hi`)>>1 and stay in PROBE.
- DONE lasts one cycle with `done`=1, then returns to IDLE.
- `start` is ignored while in PROBE or DONE.
- `guess` holds its last value in IDLE and DONE.

## Timing
- Reset values:
  - state IDLE, `lo`=0, `hi`=2^W-1.
  - `guess`=0, `busy`=0, `done`=0, `err`=0, `result`=0, `probes`=0.
- Reset mid-search aborts immediately to these values. No `done` pulse is produced.
- Edge sequence for a search:
  - Edge E0 (start sampled): `busy` rises and the first `guess` is valid after E0.
  - Edges E1..Ek: the k flag samples. The comparator must settle within one cycle.
  - `done` is high for the cycle after Ek; `busy` falls at Ek.
  - Start-to-done latency is k+1 cycles, with 1 ≤ k ≤ W+1.
- `result`, `err` and `probes` are valid when `done` is high and stable until the next accepted `start`.
- `start` held high continuously starts a new search in the cycle after DONE (IDLE sampled).

## Test plan
All scenarios use W=4 with an ideal comparator.
- Target 7: `start` → `guess` 7, match at E1 → `done` high one cycle, `result`=7, `probes`=1, `err`=0.
- Target 15: guesses 7, 11, 13, 14, 15 → `result`=15, `probes`=5, latency 6 cycles.
- Target 0: guesses 7, 3, 1, 0 → `result`=0, `probes`=4, `err`=0.
- Fault injection:
  - All flags forced 0 → `err`=1 after 1 probe, `result`=7.
  - `a_gt_b` stuck at 1 → guesses 7, 11, 13, 14, 15, then `err`=1 after 5 probes, `result`=15.
- Pulse `start` again during PROBE (target 12) → ignored, search completes normally with `result`=12. Then assert `rst_n`=0 mid-search on a new run → all outputs at reset values next cycle, no `done` pulse.

Source files
------------

// File: rtl/cmp_search.sv
// Binary-search engine: drives the b side of a magnitude comparator
// and recovers the unknown a operand from the eq/gt/lt verdicts.
module cmp_search #(
  parameter int W = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  output logic [W-1:0]              guess,
  input  logic                      a_eq_b,
  input  logic                      a_gt_b,
  input  logic                      a_lt_b,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic [W-1:0]              result,
  output logic [$clog2(W+2)-1:0]    probes
);

  localparam int CW = $clog2(W+2);

  localparam logic [W:0]   HI_INIT = {1'b0, {W{1'b1}}};
  localparam logic [W-1:0] G_INIT  = {1'b0, {(W-1){1'b1}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_PROBE,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [W:0]    lo_q, lo_d;
  logic [W:0]    hi_q, hi_d;
  logic [W-1:0]  guess_q, guess_d;
  logic          err_q, err_d;
  logic [W-1:0]  result_q, result_d;
  logic [CW-1:0] probes_q, probes_d;

  logic [2:0]    flags;
  logic          onehot;
  logic [W:0]    gx;
  logic [W:0]    lo_n, hi_n, sum;
  logic          borrow, empty;

  assign flags  = {a_eq_b, a_gt_b, a_lt_b};
  assign onehot = (flags == 3'b100) ||
                  (flags == 3'b010) ||
                  (flags == 3'b001);
  assign gx     = {1'b0, guess_q};

  always_comb begin
    state_d  = state_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    guess_d  = guess_q;
    err_d    = err_q;
    result_d = result_q;
    probes_d = probes_q;
    lo_n     = lo_q;
    hi_n     = hi_q;
    borrow   = 1'b0;
    empty    = 1'b0;
    sum      = '0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_PROBE;
          lo_d     = '0;
          hi_d     = HI_INIT;
          guess_d  = G_INIT;
          err_d    = 1'b0;
          probes_d = '0;
        end
      end

      S_PROBE: begin
        probes_d = probes_q + CW'(1);
        if (!onehot) begin
          err_d    = 1'b1;
          result_d = guess_q;
          state_d  = S_DONE;
        end else begin
          unique case (1'b1)
            a_eq_b: begin
              result_d = guess_q;
              state_d  = S_DONE;
            end
            a_gt_b: begin
              lo_n = gx + (W+1)'(1);
            end
            a_lt_b: begin
              // guess of zero wraps hi; the borrow flags the empty range
              hi_n   = gx - (W+1)'(1);
              borrow = (guess_q == '0);
            end
            default: ;
          endcase
          if (!a_eq_b) begin
            empty = borrow || (lo_n > hi_n);
            lo_d  = lo_n;
            hi_d  = hi_n;
            sum   = lo_n + hi_n;
            if (empty) begin
              err_d    = 1'b1;
              result_d = guess_q;
              state_d  = S_DONE;
            end else begin
              guess_d = sum[W:1];
            end
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      lo_q     <= '0;
      hi_q     <= HI_INIT;
      guess_q  <= '0;
      err_q    <= 1'b0;
      result_q <= '0;
      probes_q <= '0;
    end else begin
      state_q  <= state_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      guess_q  <= guess_d;
      err_q    <= err_d;
      result_q <= result_d;
      probes_q <= probes_d;
    end
  end

  assign guess  = guess_q;
  assign busy   = (state_q == S_PROBE);
  assign done   = (state_q == S_DONE);
  assign err    = err_q;
  assign result = result_q;
  assign probes = probes_q;

endmodule

// File: tb/tb_cmp_search.sv
// Bench for cmp_search: ideal and faulty comparators against
// an integer binary-search reference.
module tb_cmp_search;

  localparam int W  = 4;
  localparam int CW = $clog2(W+2);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          a_eq_b, a_gt_b, a_lt_b;
  logic [W-1:0]  guess;
  logic          busy, done, err;
  logic [W-1:0]  result;
  logic [CW-1:0] probes;

  int checks = 0;
  int errors = 0;
  int mode   = 0;
  int target = 0;
  int exp_q[$];
  int got_q[$];

  cmp_search #(.W(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .guess  (guess),
    .a_eq_b (a_eq_b),
    .a_gt_b (a_gt_b),
    .a_lt_b (a_lt_b),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .result (result),
    .probes (probes)
  );

  always #5 clk = ~clk;

  // mode 0: ideal, 1: all flags low, 2: gt stuck high
  always_comb begin
    a_eq_b = 1'b0;
    a_gt_b = 1'b0;
    a_lt_b = 1'b0;
    case (mode)
      0: begin
        a_eq_b = (target == int'(guess));
        a_gt_b = (target >  int'(guess));
        a_lt_b = (target <  int'(guess));
      end
      2: a_gt_b = 1'b1;
      default: ;
    endcase
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model(input int t, input int m,
                                output int res, output int e);
    int lo, hi, g;
    bit gt;
    exp_q.delete();
    lo = 0;
    hi = (1 << W) - 1;
    res = 0;
    e = 0;
    for (int i = 0; i < 32; i++) begin
      g = (lo + hi) / 2;
      exp_q.push_back(g);
      if (m == 1) begin
        e = 1; res = g; break;
      end
      if (m == 0 && t == g) begin
        res = g; break;
      end
      gt = (m == 2) || (t > g);
      if (gt) lo = g + 1;
      else hi = g - 1;
      if (lo > hi) begin
        e = 1; res = g; break;
      end
    end
  endfunction

  task automatic run(input string nm, input int t, input int m,
                     input bit poke);
    int er, ee, lat, n;
    model(t, m, er, ee);
    mode = m;
    target = t;
    got_q.delete();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    lat = 1;
    while (!done && lat < 20) begin
      if (busy) got_q.push_back(int'(guess));
      start = (poke && lat == 2);
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check({nm, "_done"}, int'(done), 1);
    check({nm, "_result"}, int'(result), er);
    check({nm, "_err"}, int'(err), ee);
    check({nm, "_probes"}, int'(probes), exp_q.size());
    check({nm, "_latency"}, lat, exp_q.size() + 1);
    check({nm, "_nguess"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_guess%0d", nm, i), got_q[i], exp_q[i]);
    @(negedge clk);
    check({nm, "_pulse"}, int'(done), 0);
    check({nm, "_idle"}, int'(busy), 0);
    check({nm, "_hold"}, int'(result), er);
  endtask

  task automatic check_reset(input string nm);
    check({nm, "_guess"}, int'(guess), 0);
    check({nm, "_busy"}, int'(busy), 0);
    check({nm, "_done"}, int'(done), 0);
    check({nm, "_err"}, int'(err), 0);
    check({nm, "_result"}, int'(result), 0);
    check({nm, "_probes"}, int'(probes), 0);
  endtask

  initial begin
    int t;
    repeat (2) @(negedge clk);
    check_reset("rst");
    rst_n = 1'b1;

    run("t7", 7, 0, 1'b0);
    run("t15", 15, 0, 1'b0);
    run("t0", 0, 0, 1'b0);
    run("nofl", 5, 1, 1'b0);
    run("gtst", 3, 2, 1'b0);
    run("poke12", 12, 0, 1'b1);

    for (int i = 0; i < 10; i++) begin
      t = int'($urandom_range(0, (1 << W) - 1));
      run($sformatf("rnd%0d", i), t, 0, 1'b0);
    end

    // abort a search with reset
    mode = 0;
    target = 9;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk);
    check_reset("abort");
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("abort_nodone%0d", i), int'(done), 0);
    end

    run("post", 9, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
